// File: rtl/serial_alu_addsub.sv
// Bit-serial add/sub/inc/dec unit, operands LSB-first, one bit per clock.
// Result bit is combinational; end-of-word flags are registered.
module serial_alu_addsub #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       a,
  input  logic       b,
  output logic       y,
  output logic       busy,
  output logic       last,
  output logic       done,
  output logic       carry_flag,
  output logic       ovf_flag,
  output logic       zero_flag
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_DEC = 2'b11;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0] idx;
  logic [1:0]    op_q;
  logic          carry_q;
  logic          acc_q;

  logic accept;
  logic b_e;
  logic cin0;
  logic c;
  logic cout;
  logic sum;
  logic acc_in;
  logic acc_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (last && !start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == RUN);
    last   = busy && (idx == LAST_IDX);
    accept = start && (!busy || last);
    y      = busy & sum;
  end

  always_comb begin
    b_e  = b;
    cin0 = 1'b0;
    unique case (op_q)
      OP_ADD: begin b_e = b;    cin0 = 1'b0; end
      OP_SUB: begin b_e = ~b;   cin0 = 1'b1; end
      OP_INC: begin b_e = 1'b0; cin0 = 1'b1; end
      OP_DEC: begin b_e = 1'b1; cin0 = 1'b0; end
      default: begin b_e = b;   cin0 = 1'b0; end
    endcase
  end

  // Bit 0 takes the op-specific carry-in; later bits chain the register.
  always_comb begin
    c       = (idx == '0) ? cin0 : carry_q;
    sum     = a ^ b_e ^ c;
    cout    = (a & b_e) | (a & c) | (b_e & c);
    acc_in  = (idx == '0) ? 1'b1 : acc_q;
    acc_nxt = acc_in & ~sum;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx        <= '0;
      op_q       <= OP_ADD;
      carry_q    <= 1'b0;
      acc_q      <= 1'b1;
      done       <= 1'b0;
      carry_flag <= 1'b0;
      ovf_flag   <= 1'b0;
      zero_flag  <= 1'b0;
    end else begin
      done <= last;
      if (busy) begin
        carry_q <= cout;
        acc_q   <= acc_nxt;
        idx     <= last ? '0 : idx + CW'(1);
      end
      if (last) begin
        carry_flag <= cout;
        ovf_flag   <= c ^ cout;
        zero_flag  <= acc_nxt;
      end
      if (accept) begin
        op_q <= op;
        idx  <= '0;
      end
    end
  end

endmodule
